// File: rtl/long_op_scoreboard.sv
// -----------------------------------------------------------------------------
// long_op_scoreboard
//
// Tracks the destination registers of in-flight long-latency operations
// (variable-latency loads, multi-cycle mul/div) from EX issue until writeback,
// and asks the ID stage to stall/bubble when the instruction there reads or
// rewrites a pending register, or when the outstanding-op budget is used up.
// The stall request is ORed with the load-use detector by pipeline control.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   issue_valid/_rd_addr/_reg_w   long op leaving ID into EX this cycle
//   wb_valid/wb_rd_addr           long op completing writeback this cycle
//   Rs1Addr/Rs2Addr/rs1_used/rs2_used  ID-stage sources
//   id_rd_addr/id_reg_w/id_long       ID-stage destination / op class
//   IF_ID_w                  IF/ID write enable (0 = hold)
//   ID_EX_Flush_1            bubble into ID/EX
//   busy                     pending-register bitmap (bit 0 always 0)
//   pending_cnt              number of outstanding long ops
//   full                     pending_cnt == MAX_PENDING
//   sb_err                   sticky protocol-error flag
// -----------------------------------------------------------------------------
module long_op_scoreboard #(
  parameter int ADDR_WIDTH  = 5,
  parameter int NUM_REGS    = 32,
  parameter int MAX_PENDING = 4,
  parameter int CNT_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd_addr,
  input  logic                  issue_reg_w,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_rd_addr,
  input  logic [ADDR_WIDTH-1:0] Rs1Addr,
  input  logic [ADDR_WIDTH-1:0] Rs2Addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                  id_reg_w,
  input  logic                  id_long,
  output logic                  IF_ID_w,
  output logic                  ID_EX_Flush_1,
  output logic [NUM_REGS-1:0]   busy,
  output logic [CNT_WIDTH-1:0]  pending_cnt,
  output logic                  full,
  output logic                  sb_err
);

  logic [NUM_REGS-1:0]  r_busy;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_err;

  logic [NUM_REGS-1:0]  w_busy_next;
  logic [NUM_REGS-1:0]  w_iss_mask;
  logic [NUM_REGS-1:0]  w_wb_mask;
  logic [CNT_WIDTH-1:0] w_cnt_next;

  logic w_full;
  logic w_iss_req;
  logic w_wb_hit;
  logic w_same_reg;
  logic w_iss_free;
  logic w_iss_ok;
  logic w_err_now;
  logic w_raw;
  logic w_waw;
  logic w_cap;
  logic w_hz;

  assign w_full = (r_cnt == CNT_WIDTH'(MAX_PENDING));

  // An issue only means something if it writes a real register.
  assign w_iss_req  = issue_valid & issue_reg_w & (issue_rd_addr != '0);
  // busy[0] is constant 0, so a writeback to x0 is never a hit.
  assign w_wb_hit   = wb_valid & r_busy[wb_rd_addr];
  assign w_same_reg = w_wb_hit & (wb_rd_addr == issue_rd_addr);
  // A busy destination is still acceptable when this very edge retires it:
  // the bit stays set and the count nets to zero change.
  assign w_iss_free = ~r_busy[issue_rd_addr] | w_same_reg;
  // Capacity is judged before this edge's writeback frees a slot.
  assign w_iss_ok   = w_iss_req & ~w_full & w_iss_free;

  assign w_err_now  = (w_iss_req & w_full)
                    | (w_iss_req & ~w_full & ~w_iss_free)
                    | (wb_valid & ~w_wb_hit);

  // Per-register set/clear decode; x0 is hard-wired idle.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == 0) begin : g_x0
      assign w_iss_mask[gi]  = 1'b0;
      assign w_wb_mask[gi]   = 1'b0;
      assign w_busy_next[gi] = 1'b0;
    end else begin : g_xn
      assign w_iss_mask[gi]  = w_iss_ok & (issue_rd_addr == ADDR_WIDTH'(gi));
      assign w_wb_mask[gi]   = w_wb_hit & (wb_rd_addr == ADDR_WIDTH'(gi));
      // Set wins over clear so same-register issue+writeback leaves it busy.
      assign w_busy_next[gi] = (r_busy[gi] & ~w_wb_mask[gi]) | w_iss_mask[gi];
    end
  end

  // Count tracks popcount(busy); an accepted issue never occurs when full,
  // and a hit writeback never occurs when empty, so it cannot wrap.
  always_comb begin
    w_cnt_next = r_cnt;
    unique case ({w_iss_ok, w_wb_hit})
      2'b10:   w_cnt_next = r_cnt + CNT_WIDTH'(1);
      2'b01:   w_cnt_next = r_cnt - CNT_WIDTH'(1);
      default: w_cnt_next = r_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      r_cnt  <= w_cnt_next;
      r_err  <= r_err | w_err_now;
    end
  end

  // Hazards look only at registered state: a register being written back
  // this cycle still stalls, releasing one cycle later.
  assign w_raw = (rs1_used & r_busy[Rs1Addr]) | (rs2_used & r_busy[Rs2Addr]);
  assign w_waw = id_reg_w & r_busy[id_rd_addr];
  assign w_cap = id_long & w_full;
  assign w_hz  = w_raw | w_waw | w_cap;

  assign IF_ID_w       = ~w_hz;
  assign ID_EX_Flush_1 = w_hz;
  assign busy          = r_busy;
  assign pending_cnt   = r_cnt;
  assign full          = w_full;
  assign sb_err        = r_err;

endmodule

// File: tb/tb_long_op_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_long_op_scoreboard
//
// Directed walk through the scoreboard's main scenarios followed by a random
// phase. The reference model keeps the set of pending destinations as a queue
// of register numbers and derives every expected output from it.
// -----------------------------------------------------------------------------
module tb_long_op_scoreboard;

  localparam int AW = 5;
  localparam int NR = 32;
  localparam int MP = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [AW-1:0] issue_rd_addr;
  logic          issue_reg_w;
  logic          wb_valid;
  logic [AW-1:0] wb_rd_addr;
  logic [AW-1:0] Rs1Addr;
  logic [AW-1:0] Rs2Addr;
  logic          rs1_used;
  logic          rs2_used;
  logic [AW-1:0] id_rd_addr;
  logic          id_reg_w;
  logic          id_long;
  logic          IF_ID_w;
  logic          ID_EX_Flush_1;
  logic [NR-1:0] busy;
  logic [CW-1:0] pending_cnt;
  logic          full;
  logic          sb_err;

  long_op_scoreboard #(
    .ADDR_WIDTH(AW), .NUM_REGS(NR), .MAX_PENDING(MP), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd_addr(issue_rd_addr), .issue_reg_w(issue_reg_w),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
    .Rs1Addr(Rs1Addr), .Rs2Addr(Rs2Addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .id_rd_addr(id_rd_addr), .id_reg_w(id_reg_w), .id_long(id_long),
    .IF_ID_w(IF_ID_w), .ID_EX_Flush_1(ID_EX_Flush_1), .busy(busy),
    .pending_cnt(pending_cnt), .full(full), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the list of registers with an op in flight.
  int q[$];
  bit m_err;

  function automatic bit inq(int a);
    foreach (q[i]) if (q[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NR-1:0] exp_busy();
    logic [NR-1:0] b = '0;
    foreach (q[i]) b[q[i]] = 1'b1;
    return b;
  endfunction

  task automatic chk(string tag, logic [NR-1:0] obs, logic [NR-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(string tag);
    bit hz;
    hz = (rs1_used && inq(int'(Rs1Addr))) || (rs2_used && inq(int'(Rs2Addr)))
      || (id_reg_w && inq(int'(id_rd_addr))) || (id_long && q.size() == MP);
    chk({tag, ".busy"},  busy,                exp_busy());
    chk({tag, ".cnt"},   NR'(pending_cnt),    NR'(q.size()));
    chk({tag, ".full"},  NR'(full),           NR'(q.size() == MP));
    chk({tag, ".err"},   NR'(sb_err),         NR'(m_err));
    chk({tag, ".ifidw"}, NR'(IF_ID_w),        NR'(!hz));
    chk({tag, ".flush"}, NR'(ID_EX_Flush_1),  NR'(hz));
  endtask

  // Applies one rising edge's worth of rules to the pending list.
  task automatic model_step();
    bit req, was_full, wb_ok, same;
    if (rst) begin
      q.delete();
      m_err = 1'b0;
      return;
    end
    req      = issue_valid && issue_reg_w && issue_rd_addr != 0;
    was_full = (q.size() == MP);
    wb_ok    = wb_valid && inq(int'(wb_rd_addr));
    same     = wb_ok && (wb_rd_addr == issue_rd_addr);
    if (wb_valid && !wb_ok) m_err = 1'b1;
    if (req && was_full) m_err = 1'b1;
    else if (req && inq(int'(issue_rd_addr)) && !same) m_err = 1'b1;
    if (wb_ok) begin
      foreach (q[i]) if (q[i] == int'(wb_rd_addr)) begin q.delete(i); break; end
    end
    if (req && !was_full && !inq(int'(issue_rd_addr))) q.push_back(int'(issue_rd_addr));
  endtask

  // Inputs are set at a falling edge; check, clock, and return at the next one.
  task automatic tick(string tag);
    #1;
    check_state(tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_in();
    issue_valid = 0; issue_rd_addr = '0; issue_reg_w = 0;
    wb_valid = 0; wb_rd_addr = '0;
    Rs1Addr = '0; Rs2Addr = '0; rs1_used = 0; rs2_used = 0;
    id_rd_addr = '0; id_reg_w = 0; id_long = 0;
  endtask

  task automatic issue(int rd);
    issue_valid = 1; issue_reg_w = 1; issue_rd_addr = AW'(rd);
  endtask

  task automatic wb(int rd);
    wb_valid = 1; wb_rd_addr = AW'(rd);
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    q.delete();
    m_err = 1'b0;
    #1;
    check_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick("idle");

    // Issue x5, RAW stall, writeback, release one cycle later.
    issue(5); tick("iss5");
    clear_in();
    chk("tp1.busy", busy, NR'(32'h20));
    chk("tp1.cnt",  NR'(pending_cnt), NR'(1));
    Rs1Addr = 5; rs1_used = 1;
    #1;
    chk("tp1.stall", NR'(IF_ID_w), NR'(0));
    tick("raw5");
    wb(5); tick("wb5");
    clear_in(); Rs1Addr = 5; rs1_used = 1;
    #1;
    chk("tp1.release", NR'(IF_ID_w), NR'(1));
    chk("tp1.cnt0",    NR'(pending_cnt), NR'(0));
    tick("rel5");

    // Fill to capacity, capacity stall, issue while full.
    clear_in();
    for (int r = 1; r <= 4; r++) begin issue(r); tick("fill"); end
    clear_in();
    chk("tp2.full", NR'(full), NR'(1));
    id_long = 1; tick("cap");
    clear_in(); issue(6); wb(4); tick("iss_full");
    clear_in();
    chk("tp2.err",  NR'(sb_err), NR'(1));
    chk("tp2.busy", busy, NR'(32'h0E));

    // Same-cycle issue x7 + writeback x3, then same-register issue+wb.
    issue(7); wb(3); tick("iss7wb3");
    clear_in();
    chk("tp3.busy", busy, NR'(32'h86));
    issue(7); wb(7); tick("same7");
    clear_in();
    chk("tp3.same", busy, NR'(32'h86));

    // rd = 0 issue, non-busy writeback.
    issue(0); tick("iss0");
    clear_in(); wb(9); tick("wb9");
    clear_in();

    // WAW on x8.
    wb(7); tick("wb7");
    clear_in(); issue(8); tick("iss8");
    clear_in(); id_reg_w = 1; id_rd_addr = 8; tick("waw");
    clear_in(); id_rd_addr = 8; tick("nowaw");
    chk("tp5.busy", busy, NR'(32'h106));

    // Asynchronous reset with 3 pending, then an orphan writeback.
    clear_in();
    #2 rst = 1'b1;
    q.delete(); m_err = 1'b0;
    #1;
    check_state("async_rst");
    @(negedge clk);
    rst = 1'b0;
    wb(2); tick("orphan");
    clear_in();
    chk("tp6.err", NR'(sb_err), NR'(1));

    // Random phase.
    for (int c = 0; c < 400; c++) begin
      clear_in();
      issue_valid   = 1'($urandom_range(0, 1));
      issue_reg_w   = ($urandom_range(0, 3) != 0);
      issue_rd_addr = AW'($urandom_range(0, 9));
      wb_valid      = 1'($urandom_range(0, 1));
      if (q.size() != 0 && $urandom_range(0, 3) != 0)
        wb_rd_addr = AW'(q[$urandom_range(0, q.size() - 1)]);
      else
        wb_rd_addr = AW'($urandom_range(0, 9));
      Rs1Addr    = AW'($urandom_range(0, 9));
      Rs2Addr    = AW'($urandom_range(0, 9));
      rs1_used   = 1'($urandom_range(0, 1));
      rs2_used   = 1'($urandom_range(0, 1));
      id_rd_addr = AW'($urandom_range(0, 9));
      id_reg_w   = 1'($urandom_range(0, 1));
      id_long    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        q.delete(); m_err = 1'b0;
        #1;
        check_state("rnd_rst");
      end
      tick("rnd");
      rst = 1'b0;
    end
    clear_in();
    tick("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/long_op_scoreboard.md
Name: long_op_scoreboard

Overview:
- Tracks destination registers of in-flight long-latency operations (variable-latency loads, multi-cycle mul/div) from EX issue until writeback.
- Generates front-end stall/bubble controls for the ID stage when an instruction reads or rewrites a register still pending (RAW/WAW), or when the outstanding-operation budget is exhausted.
- Sits beside the single-cycle load-use detector; the two stall requests are ORed by the pipeline control.

Parameters:
- ADDR_WIDTH, 5, register address width (`ADDR_WIDTH from SYSTEM_DEF.vh).
- NUM_REGS, 32, architectural registers; x0 is never tracked.
- MAX_PENDING, 4, maximum outstanding long operations; must be ≥1 and ≤ NUM_REGS-1.
- CNT_WIDTH, 3, counter width; must hold MAX_PENDING.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  long op leaving ID into EX this cycle.
- issue_rd_addr  in  ADDR_WIDTH  destination of issuing op.
- issue_reg_w  in  1  issuing op writes a register.
- wb_valid  in  1  long op completing writeback this cycle.
- wb_rd_addr  in  ADDR_WIDTH  destination being written back.
- Rs1Addr  in  ADDR_WIDTH  ID-stage source 1.
- Rs2Addr  in  ADDR_WIDTH  ID-stage source 2.
- rs1_used  in  1  ID instruction reads Rs1.
- rs2_used  in  1  ID instruction reads Rs2.
- id_rd_addr  in  ADDR_WIDTH  ID-stage destination.
- id_reg_w  in  1  ID instruction writes a register.
- id_long  in  1  ID instruction is a long op.
- IF_ID_w  out  1  IF/ID write enable (0 = hold).
- ID_EX_Flush_1  out  1  insert bubble into ID/EX.
- busy  out  NUM_REGS  pending bitmap; bit 0 always 0.
- pending_cnt  out  CNT_WIDTH  outstanding long ops.
- full  out  1  pending_cnt == MAX_PENDING.
- sb_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): busy = 0, pending_cnt = 0, sb_err = 0. Combinational outputs follow: IF_ID_w = 1, ID_EX_Flush_1 = 0, full = 0. In-flight ops are forgotten.
- Accepted issue (rising edge): issue_valid & issue_reg_w & issue_rd_addr != 0 & !full. Sets busy[issue_rd_addr]; pending_cnt +1.
- issue_valid with issue_reg_w = 0, or rd = 0: no state change, no count.
- Issue while full: ignored; sets sb_err.
- Issue to a register already busy: sets sb_err; bit stays 1; count unchanged.
- Accepted writeback: wb_valid & busy[wb_rd_addr]. Clears the bit; pending_cnt -1.
- wb_valid to a non-busy register or x0: ignored; sets sb_err.
- Simultaneous accepted issue and writeback, different registers: set one bit, clear the other; pending_cnt unchanged.
- Simultaneous issue and writeback, same register: the bit ends at 1; pending_cnt unchanged.
- Full/count: full is tested before that edge's writeback. Issue while full is rejected even if a writeback occurs the same cycle.
- Counter never wraps; pending_cnt always equals popcount(busy).
- Hazard (combinational from registered state only; no same-cycle writeback bypass):
  - raw = (rs1_used & busy[Rs1Addr]) | (rs2_used & busy[Rs2Addr])
  - waw = id_reg_w & busy[id_rd_addr]
  - cap = id_long & full
  - hz = raw | waw | cap
  - IF_ID_w = !hz; ID_EX_Flush_1 = hz.
  - Stall releases the cycle after the clearing writeback edge (one conservative cycle).
- Addresses equal to 0 never hazard, since busy[0] is constant 0.
- Latency: issue and writeback take effect on busy/pending_cnt one edge later; stall outputs react combinationally to busy and the ID inputs.

Test Plan:
- Reset then issue x5 (issue_valid=1, rd=5, reg_w=1) → next cycle busy=0x20, pending_cnt=1. ID reads Rs1=5 with rs1_used=1 → IF_ID_w=0, ID_EX_Flush_1=1. Writeback rd=5 → stall holds that cycle and drops the next cycle; pending_cnt=0.
- Issue x1, x2, x3, x4 on consecutive cycles → full=1. ID id_long=1 → stall. Issue x6 while full → ignored, sb_err=1, busy=0x1E.
- Same-cycle issue x7 + writeback x3 (x3 busy) → busy gains bit 7, loses bit 3; pending_cnt unchanged.
- Issue with rd=0, and writeback to non-busy x9 → busy unchanged, pending_cnt unchanged, sb_err=1 after the writeback.
- WAW: x8 busy, ID id_reg_w=1, id_rd_addr=8, no sources used → stall. Repeat with id_reg_w=0 → no stall.
- Assert rst mid-operation with 3 ops pending → immediately busy=0, pending_cnt=0, full=0, IF_ID_w=1, sb_err=0. A writeback arriving after reset sets sb_err=1.
